// File: rtl/code_tx.sv
// rtl/code_tx.sv - 4-bit switch code serial transmitter with start/stop framing.
// Optional even parity bit when CODE_TX_PARITY_EN is defined.
module code_tx #(
    parameter int CLK_DIV = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] led
);

`ifdef CODE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_M2 = 16'(CLK_DIV - 2);

    state_t      state_q;
    logic [15:0] timer_q;
    logic [3:0]  shift_q;
    logic [1:0]  bitcnt_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic [2:0]  led_q;
    logic        s1_q, s2_q, s3_q;
    logic [1:0]  valid_q;
    logic        armed_q;
`ifdef CODE_TX_PARITY_EN
    logic        parity_q;
`endif

    logic req;
    logic bit_end;

    // armed_q only rises once stage 2 holds a genuine high sample, so a
    // press held through reset release cannot look like a fresh falling edge.
    assign req     = armed_q & s3_q & ~s2_q;
    assign bit_end = (timer_q == DIV_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            led_q    <= 3'b111;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            valid_q  <= '0;
            armed_q  <= 1'b0;
`ifdef CODE_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            s1_q    <= send;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= {valid_q[0], 1'b1};
            if (valid_q[1] && s2_q) begin
                armed_q <= 1'b1;
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    timer_q <= '0;
                    if (req) begin
                        shift_q  <= sw;
                        bitcnt_q <= '0;
`ifdef CODE_TX_PARITY_EN
                        parity_q <= ^sw;
`endif
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        led_q    <= 3'b110;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        if (bitcnt_q == 2'd3) begin
`ifdef CODE_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            shift_q  <= {1'b0, shift_q[3:1]};
                            bitcnt_q <= bitcnt_q + 2'd1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
`ifdef CODE_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                        // done is registered, so raise it one cycle early to land on the last stop cycle
                        if (timer_q == DIV_M2) begin
                            done_q <= 1'b1;
                            led_q  <= 3'b101;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign led  = led_q;

endmodule

// File: tb/tb_code_tx.sv
// tb/tb_code_tx.sv - directed bench for code_tx with CLK_DIV=4.
module tb_code_tx;

    localparam int CLK_DIV = 4;
`ifdef CODE_TX_PARITY_EN
    localparam int NBITS = 7;
    localparam logic [6:0] PAT_1100 = 7'b1011000;
    localparam logic [6:0] PAT_1011 = 7'b1110110;
    localparam logic [6:0] PAT_0001 = 7'b1100010;
`else
    localparam int NBITS = 6;
    localparam logic [6:0] PAT_1100 = 7'b0111000;
    localparam logic [6:0] PAT_1011 = 7'b0110110;
    localparam logic [6:0] PAT_0001 = 7'b0100010;
`endif
    localparam int FLEN = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'b0000;
    logic       send = 1'b1;
    logic       tx;
    logic       busy;
    logic       done;
    logic [2:0] led;

    int n_vec = 0;
    int n_err = 0;

    code_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .send (send),
        .tx   (tx),
        .busy (busy),
        .done (done),
        .led  (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge where send has just been driven low.
    // mode 1: re-press and change sw mid-frame; mode 2: re-press landing on the done cycle.
    task automatic check_frame(input string tag, input logic [6:0] pat, input int rel_after, input int mode);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk({tag, "_lat_tx"}, 8'(tx), 8'd1);
            chk({tag, "_lat_busy"}, 8'(busy), 8'd0);
            if (rel_after == k + 1) send = 1'b1;
        end
        for (int c = 0; c < FLEN; c++) begin
            @(negedge clk);
            chk({tag, "_tx"}, 8'(tx), 8'(pat[c / CLK_DIV]));
            chk({tag, "_busy"}, 8'(busy), 8'd1);
            chk({tag, "_done"}, 8'(done), (c == FLEN - 1) ? 8'd1 : 8'd0);
            chk({tag, "_led"}, 8'(led), (c == FLEN - 1) ? 8'b101 : 8'b110);
            if (mode == 1) begin
                if (c == 4) begin
                    send = 1'b1;
                    sw   = 4'b0001;
                end
                if (c == 10) send = 1'b0;
            end
            if (mode == 2) begin
                if (c == 2) send = 1'b1;
                if (c == FLEN - 3) send = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_end_tx"}, 8'(tx), 8'd1);
        chk({tag, "_end_busy"}, 8'(busy), 8'd0);
        chk({tag, "_end_done"}, 8'(done), 8'd0);
        chk({tag, "_end_led"}, 8'(led), 8'b101);
        if (mode != 0) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                chk({tag, "_no_second"}, 8'(busy), 8'd0);
            end
        end
    endtask

    initial begin
        int done_seen;

        repeat (3) @(negedge clk);
        chk("rst_tx", 8'(tx), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_led", 8'(led), 8'b111);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_led", 8'(led), 8'b111);
        chk("idle_busy", 8'(busy), 8'd0);

        // basic frame
        sw   = 4'b1100;
        send = 1'b0;
        check_frame("f1100", PAT_1100, 0, 0);
        send = 1'b1;
        repeat (4) @(negedge clk);

        // second press and sw change during a frame
        sw   = 4'b1011;
        send = 1'b0;
        check_frame("f1011", PAT_1011, 0, 1);
        send = 1'b1;
        repeat (4) @(negedge clk);

        // press that lands on the done cycle
        sw   = 4'b0001;
        send = 1'b0;
        check_frame("f0001_done", PAT_0001, 0, 2);
        send = 1'b1;
        repeat (4) @(negedge clk);

        // reset during data bit 2 of sw=0010 (bit 2 is 0)
        sw   = 4'b0010;
        send = 1'b0;
        repeat (3) @(negedge clk);
        repeat (13) @(negedge clk);
        chk("abort_pre_tx", 8'(tx), 8'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 8'(tx), 8'd1);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_led", 8'(led), 8'b111);
        chk("abort_done", 8'(done), 8'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", 8'(done_seen), 8'd0);
        chk("abort_idle", 8'(busy), 8'd0);
        send = 1'b1;
        repeat (4) @(negedge clk);
        sw   = 4'b0001;
        send = 1'b0;
        check_frame("after_abort", PAT_0001, 0, 0);
        send = 1'b1;
        repeat (4) @(negedge clk);

        // held low 100 cycles yields one frame
        sw   = 4'b1100;
        send = 1'b0;
        check_frame("hold1", PAT_1100, 0, 0);
        for (int k = 0; k < 100 - FLEN - 3; k++) begin
            @(negedge clk);
            chk("hold_no_repeat", 8'(busy), 8'd0);
        end
        send = 1'b1;
        repeat (4) @(negedge clk);
        sw   = 4'b1011;
        send = 1'b0;
        check_frame("hold2", PAT_1011, 0, 0);
        send = 1'b1;
        repeat (4) @(negedge clk);

        // sub-cycle glitch, seen by no edge
        @(posedge clk);
        #2 send = 1'b0;
        #4 send = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("glitch_idle", 8'(busy), 8'd0);
        end
        sw   = 4'b1100;
        send = 1'b0;
        check_frame("two_cycle", PAT_1100, 2, 0);
        repeat (4) @(negedge clk);

        // press held across reset release
        rst  = 1'b1;
        send = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst2_led", 8'(led), 8'b111);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("held_rst_idle", 8'(busy), 8'd0);
        end
        chk("held_rst_tx", 8'(tx), 8'd1);
        send = 1'b1;
        repeat (4) @(negedge clk);
        sw   = 4'b0001;
        send = 1'b0;
        check_frame("post_rst", PAT_0001, 0, 0);
        send = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
